// File: rtl/rr_decode_arbiter_if.sv
// Bus between the requester bank and the round-robin decode arbiter.
// master: requester side (drives req/done, observes the grant).
// slave : arbiter side (observes req/done, drives the grant).
interface rr_decode_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one 16-way one-hot select among 16 requesters.
// The winner's index is decoded to a one-hot grant (4x16 decoder mapping) and
// held until the owner pulses done or drops its request. A mandatory IDLE
// cycle separates consecutive grants.
// Optional build macro HOLD_TIMEOUT_EN adds an 8-bit hold counter that revokes
// a grant after MAX_HOLD cycles and pulses timeout; without it timeout is 0.
module rr_decode_arbiter #(
  parameter logic [7:0] MAX_HOLD = 8'd255
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_decode_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Same index-to-one-hot mapping as the shared 4x16 decoder.
  function automatic logic [15:0] decode_4to16(input logic [3:0] idx);
    decode_4to16 = 16'h0001 << idx;
  endfunction

  logic [0:0]  state_q;
  logic [3:0]  last_q;
  logic [15:0] gnt_q;
  logic [3:0]  gnt_idx_q;
  logic        gnt_valid_q;
  logic        timeout_q;

  logic [3:0]  cand;
  logic [3:0]  win_idx;
  logic        win_found;
  logic        owner_req;
  logic        expire;
  logic        release_grant;
  logic        timeout_next;

  // Rotating priority search starting just after the last owner.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cand = last_q + 4'(i + 1);
      if (!win_found && bus.req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

`ifdef HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt_q;

  assign expire = (state_q == ST_BUSY) && (hold_cnt_q == (MAX_HOLD - 8'd1));

  // Hold counter: cleared when a grant is issued, counts each held cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
    end else if (state_q == ST_IDLE) begin
      if (win_found) hold_cnt_q <= 8'd0;
    end else if (!release_grant) begin
      hold_cnt_q <= hold_cnt_q + 8'd1;
    end
  end
`else
  // MAX_HOLD has no effect without the hold timer.
  logic [7:0] unused_max_hold;
  assign unused_max_hold = MAX_HOLD;
  assign expire          = 1'b0;
`endif

  assign owner_req     = bus.req[gnt_idx_q];
  assign release_grant = bus.done || !owner_req || expire;
  // done and a request drop both take precedence over expiry.
  assign timeout_next  = expire && !bus.done && owner_req;

  // Grant FSM: issue in IDLE, hold and watch for release in BUSY.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 4'd15;
      gnt_q       <= 16'h0000;
      gnt_idx_q   <= 4'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            gnt_idx_q   <= win_idx;
            gnt_q       <= decode_4to16(win_idx);
            gnt_valid_q <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (release_grant) begin
            gnt_q       <= 16'h0000;
            gnt_valid_q <= 1'b0;
            last_q      <= gnt_idx_q;
            timeout_q   <= timeout_next;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 16-way one-hot select resource among 16 requesters.
- Picks one winner and drives its 4-bit index plus the decoded 16-bit one-hot grant, the same index-to-one-hot mapping as the team's 4x16 decoder.
- Holds the grant until the owner releases it, optionally with a hold timeout.
- Sits between the requester bank and the decoded select lines of the shared datapath.

Parameters:
- MAX_HOLD, 8'd255: maximum number of cycles a grant is held. Valid range 1..255. Used only when HOLD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active low
- req  input  16  request vector; req[i] stays high while requester i wants or holds the resource
- done  input  1  single-cycle release pulse from the current owner
- gnt  output  16  registered one-hot grant; gnt[i] means requester i owns the resource
- gnt_idx  output  4  registered binary index of the owner
- gnt_valid  output  1  high while any grant is held
- timeout  output  1  single-cycle pulse when a grant is revoked by the hold timer

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hold counter=0, state=IDLE.
  - Last-owner pointer last=15, so the first search starts at index 0.
- All outputs are registered and update only on the rising edge of clk, except during asynchronous reset.
- States are IDLE and BUSY.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning (last+1) mod 16 upward with wrap-around, e.g. last=14 scans 15, 0, 1, ...
  - At the next edge: gnt_idx=winner, gnt=16'b1<<winner, gnt_valid=1, hold counter=0, state=BUSY.
  - Latency from req sampled high in IDLE to gnt visible is 1 cycle.
  - If req is zero, stay in IDLE with outputs at 0.
- BUSY:
  - gnt, gnt_idx and gnt_valid hold steady; the hold counter increments each cycle.
  - The grant is released when any of these is true:
    - done=1
    - req[gnt_idx]=0 (requester dropped its request)
    - hold counter reaches MAX_HOLD-1 (timeout feature only)
  - On release, at the next edge: gnt=0, gnt_valid=0, last=gnt_idx, state=IDLE.
  - gnt_idx keeps its last value after release; consumers qualify it with gnt_valid.
- Mandatory dead cycle: after a release there is at least one IDLE cycle with gnt=0 before the next grant. Back-to-back owners are therefore spaced 2 cycles apart at minimum.
- done while in IDLE is ignored.
- Requests from non-owners during BUSY are not sampled; they compete in the next IDLE cycle.
- Simultaneous release causes:
  - done and timer expiry in the same cycle: done wins, timeout stays 0.
  - req drop and timer expiry in the same cycle: timeout stays 0.
- timeout pulses high for exactly the one cycle in which gnt goes to 0 because of expiry.
- Invariants: gnt is always 0 or one-hot, and gnt==(16'b1<<gnt_idx) whenever gnt_valid=1.
- Reset asserted in the middle of a grant drops gnt immediately and returns last to 15.

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- Defined: the 8-bit hold counter and the MAX_HOLD expiry logic are built in, and timeout pulses as described above.
- Undefined: no counter is built, grants are held until done or a req drop, and timeout is tied to 0.

Test Plan:
- Reset, then req=16'h0001, pulse done at cycle 5 -> gnt=16'h0001 and gnt_idx=0 one cycle after req; gnt=0 one cycle after done; gnt_valid matches gnt throughout.
- req=16'hFFFF held, done pulsed every grant -> gnt_idx visits 0, 1, 2, ..., 15, 0 in order, with exactly one gnt=0 cycle between consecutive grants.
- After owner 14 releases, req=16'h4002 -> next gnt_idx=1 (wraps past 15 to 0 to 1), not 14.
- Owner 3 drops req[3] while BUSY with no done -> gnt=0 on the next edge and timeout=0.
- HOLD_TIMEOUT_EN defined, MAX_HOLD=4, req=16'h0010 held, no done -> gnt held exactly 4 cycles, timeout pulses 1 cycle as gnt clears, then after one idle cycle req[4] is re-granted. Repeat with done in the expiry cycle -> timeout=0.
- Assert rst_n low asynchronously (between clock edges) while gnt=16'h0100 -> gnt=0, gnt_valid=0 and gnt_idx=0 without waiting for a clock edge. After rst_n rises, req=16'hFFFF -> first gnt_idx=0.
